decoder_scan_n: RTL and testbench
=================================

Name: decoder_scan_n

Overview:
- Registered, parametrised N-to-2^N one-hot decoder with enable, selectable output polarity and two operating modes.
- Direct mode decodes an externally supplied select.
- Scan mode steps an internal index through all outputs, holding each one for a programmable number of cycles, for multiplexed digit and LED drive.
- Sits between control logic and display/peripheral enables. It is the clocked generalisation of the team's combinational 2-to-4 decoder.

Parameters:
- N, 2, select width; output width is 2**N (localparam OUT_W).
- ACTIVE_LOW, 0: 0 = selected output is 1; 1 = selected output is 0 and the others are 1.
- DWELL, 4: scan-mode cycles per output; must be >= 1 (localparam DW_W = $clog2(DWELL) or 1 if DWELL = 1).

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  block enable; 0 forces outputs inactive
- mode  in  1  0 = direct, 1 = scan
- sel  in  N  direct-mode select
- sel_valid  in  1  sel qualifier; direct mode only
- y  out  OUT_W  one-hot decoded outputs, polarity set by ACTIVE_LOW
- idx  out  N  index currently driven on y
- out_valid  out  1  y holds a valid decode
- wrap  out  1  one-cycle pulse when scan idx wraps from OUT_W-1 to 0

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - y = all inactive (0s, or all 1s when ACTIVE_LOW = 1)
  - idx = 0, out_valid = 0, wrap = 0, dwell counter = 0, state = IDLE
- FSM states: IDLE, DIRECT, SCAN. All transitions are evaluated on the rising edge.
  - From any state: en = 0 -> IDLE. Otherwise mode = 0 -> DIRECT, mode = 1 -> SCAN.
- IDLE:
  - y inactive, out_valid = 0, wrap = 0.
  - idx and the dwell counter hold their values.
- DIRECT:
  - If en && sel_valid at edge k, then at edge k+1: idx = sel, y = onehot(sel), out_valid = 1. Latency is 1 cycle.
  - If sel_valid = 0, y, idx and out_valid hold.
  - Entering DIRECT from IDLE: out_valid stays 0 until the first sel_valid.
  - Entering DIRECT from SCAN: y, idx and out_valid = 1 hold the last scanned value.
- SCAN:
  - sel and sel_valid are ignored.
  - Entry cycle: the dwell counter clears to 0 and y = onehot(idx) with out_valid = 1 from the next edge. The scan resumes from the current idx.
  - Each cycle the dwell counter increments. When it equals DWELL-1, it clears and idx increments modulo OUT_W.
  - y always equals onehot(idx) in the same cycle as idx; there is no extra lag.
  - wrap = 1 for exactly the one cycle in which idx becomes 0 due to an increment from OUT_W-1. An idx change caused by entry or by a direct load never asserts wrap.
  - DWELL = 1: idx advances every cycle.
- Mode change while en = 1 takes effect at the next edge. A dwell count in progress is discarded, with no partial dwell carried over.
- Exactly one bit of y is active whenever out_valid = 1; all bits are inactive whenever out_valid = 0.
- All outputs are registered. No combinational path from inputs to outputs.

Decomposition:
- Shared header/package holds:
  - mode encodings MODE_DIRECT = 1'b0, MODE_SCAN = 1'b1
  - FSM state encodings ST_IDLE, ST_DIRECT, ST_SCAN
  - polarity helper constant
- One sub-module, onehot_dec: combinational N-to-2^N decoder with ACTIVE_LOW and enable inputs.
- The top level holds the FSM, idx register, dwell counter and output registers.

Test Plan (N = 2, DWELL = 3 unless stated):
- Reset with rst = 1 mid-scan, then release -> y = 4'b0000, idx = 0, out_valid = 0 immediately on assertion; state stays IDLE until en = 1.
- Direct mode, en = 1, sel = 2, sel_valid pulse at cycle k -> y = 4'b0100, idx = 2, out_valid = 1 at k+1; sel changes to 3 with sel_valid = 0 -> y stays 4'b0100.
- Scan from idx = 0 -> y sequence 0001 x3, 0010 x3, 0100 x3, 1000 x3, 0001; wrap = 1 only on the cycle y returns to 0001.
- ACTIVE_LOW = 1, direct sel = 1 -> y = 4'b1101; en = 0 -> y = 4'b1111, out_valid = 0.
- Scan to idx = 2, then switch mode to 0 -> y holds 4'b0100 with out_valid = 1; switch back to scan -> resumes at idx 2 with a full 3-cycle dwell.
- N = 3, DWELL = 1 scan -> y walks 8 one-hot values, one per cycle; wrap pulses every 8 cycles.

Source files
------------

// File: rtl/decoder_scan_n_pkg.sv
// Shared encodings for the scanning one-hot decoder.
package decoder_scan_n_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    // Map a logical "selected" bit onto the physical output level.
    function automatic logic pol_bit(input logic active, input logic active_low);
        return active ^ active_low;
    endfunction

endpackage

// File: rtl/decoder_scan_n_onehot_dec.sv
// Combinational N-to-2^N one-hot decoder with enable and output polarity.
module onehot_dec
    import decoder_scan_n_pkg::*;
#(
    parameter int N          = 2,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic            en,
    input  logic [N-1:0]    sel,
    output logic [2**N-1:0] y
);

    localparam int OUT_W = 2**N;

    // One bit active for the selected index; all inactive when disabled.
    always_comb begin
        y = '0;
        for (int i = 0; i < OUT_W; i++) begin
            y[i] = pol_bit(en && (sel == N'(i)), ACTIVE_LOW);
        end
    end

endmodule

// File: rtl/decoder_scan_n.sv
// Registered one-hot decoder with direct-select and timed scan modes.
module decoder_scan_n
    import decoder_scan_n_pkg::*;
#(
    parameter int N          = 2,
    parameter bit ACTIVE_LOW = 1'b0,
    parameter int DWELL      = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            mode,
    input  logic [N-1:0]    sel,
    input  logic            sel_valid,
    output logic [2**N-1:0] y,
    output logic [N-1:0]    idx,
    output logic            out_valid,
    output logic            wrap
);

    localparam int OUT_W = 2**N;
    localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0] DW_LAST  = DW_W'(DWELL - 1);
    localparam logic [N-1:0]    IDX_LAST = N'(OUT_W - 1);

    state_t            state_q, state_d;
    logic [N-1:0]      idx_q, idx_d;
    logic [DW_W-1:0]   dwell_q, dwell_d;
    logic              out_valid_q, out_valid_d;
    logic              wrap_q, wrap_d;
    logic [OUT_W-1:0]  y_q, y_d;

    // Next-state logic: the state entered at this edge decides the update.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        dwell_d     = dwell_q;
        out_valid_d = out_valid_q;
        wrap_d      = 1'b0;
        if (!en) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end else if (mode == MODE_SCAN) begin
            state_d     = ST_SCAN;
            out_valid_d = 1'b1;
            if (state_q != ST_SCAN) begin
                // Entry: show current idx and start a fresh dwell.
                dwell_d = '0;
            end else if (dwell_q == DW_LAST) begin
                dwell_d = '0;
                idx_d   = idx_q + N'(1);
                wrap_d  = (idx_q == IDX_LAST);
            end else begin
                dwell_d = dwell_q + DW_W'(1);
            end
        end else begin
            state_d = ST_DIRECT;
            dwell_d = '0;
            if (sel_valid) begin
                idx_d       = sel;
                out_valid_d = 1'b1;
            end
        end
    end

    // y is always derived from the next idx/valid, so it can never lag idx.
    onehot_dec #(
        .N          (N),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_dec (
        .en  (out_valid_d),
        .sel (idx_d),
        .y   (y_d)
    );

    // FSM and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            dwell_q     <= '0;
            out_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
            y_q         <= {OUT_W{ACTIVE_LOW}};
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dwell_q     <= dwell_d;
            out_valid_q <= out_valid_d;
            wrap_q      <= wrap_d;
            y_q         <= y_d;
        end
    end

    assign y         = y_q;
    assign idx       = idx_q;
    assign out_valid = out_valid_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_decoder_scan_n.sv
// Directed bench for decoder_scan_n across three parameter sets.
module tb_decoder_scan_n;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // a: N=2 DWELL=3 active-high
    logic       a_en = 0, a_mode = 0, a_sv = 0, a_ov, a_wrap;
    logic [1:0] a_sel = 0, a_idx;
    logic [3:0] a_y;
    // b: N=2 DWELL=3 active-low
    logic       b_en = 0, b_mode = 0, b_sv = 0, b_ov, b_wrap;
    logic [1:0] b_sel = 0, b_idx;
    logic [3:0] b_y;
    // c: N=3 DWELL=1 active-high
    logic       c_en = 0, c_mode = 0, c_sv = 0, c_ov, c_wrap;
    logic [2:0] c_sel = 0, c_idx;
    logic [7:0] c_y;

    decoder_scan_n #(.N(2), .ACTIVE_LOW(1'b0), .DWELL(3)) dut_a (
        .clk(clk), .rst(rst), .en(a_en), .mode(a_mode), .sel(a_sel), .sel_valid(a_sv),
        .y(a_y), .idx(a_idx), .out_valid(a_ov), .wrap(a_wrap));
    decoder_scan_n #(.N(2), .ACTIVE_LOW(1'b1), .DWELL(3)) dut_b (
        .clk(clk), .rst(rst), .en(b_en), .mode(b_mode), .sel(b_sel), .sel_valid(b_sv),
        .y(b_y), .idx(b_idx), .out_valid(b_ov), .wrap(b_wrap));
    decoder_scan_n #(.N(3), .ACTIVE_LOW(1'b0), .DWELL(1)) dut_c (
        .clk(clk), .rst(rst), .en(c_en), .mode(c_mode), .sel(c_sel), .sel_valid(c_sv),
        .y(c_y), .idx(c_idx), .out_valid(c_ov), .wrap(c_wrap));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++; if (a_y !== 4'b0000) begin failures++; $display("FAIL reset_a_y got=%b exp=0000", a_y); end
        checks++; if (a_idx !== 2'd0 || a_ov !== 1'b0 || a_wrap !== 1'b0) begin failures++; $display("FAIL reset_a_flags idx=%0d ov=%b wrap=%b exp 0/0/0", a_idx, a_ov, a_wrap); end
        checks++; if (b_y !== 4'b1111) begin failures++; $display("FAIL reset_b_y got=%b exp=1111", b_y); end
        checks++; if (c_y !== 8'h00 || c_ov !== 1'b0) begin failures++; $display("FAIL reset_c got y=%b ov=%b exp 0/0", c_y, c_ov); end
        @(negedge clk); rst = 1'b0;
        a_en = 1; a_mode = 1;
        repeat (4) tick();
        checks++; if (a_idx !== 2'd1 || a_y !== 4'b0010) begin failures++; $display("FAIL pre_reset_scan idx=%0d y=%b exp 1/0010", a_idx, a_y); end
        #2 rst = 1'b1;
        #1;
        checks++; if (a_y !== 4'b0000 || a_idx !== 2'd0 || a_ov !== 1'b0) begin failures++; $display("FAIL async_reset y=%b idx=%0d ov=%b exp 0000/0/0", a_y, a_idx, a_ov); end
        @(negedge clk); rst = 1'b0; a_en = 0;
        repeat (3) tick();
        checks++; if (a_y !== 4'b0000 || a_ov !== 1'b0 || a_idx !== 2'd0) begin failures++; $display("FAIL idle_after_reset y=%b ov=%b idx=%0d exp 0000/0/0", a_y, a_ov, a_idx); end
    endtask

    task automatic test_direct();
        a_en = 1; a_mode = 0; a_sel = 2; a_sv = 0;
        tick();
        checks++; if (a_ov !== 1'b0 || a_y !== 4'b0000) begin failures++; $display("FAIL direct_entry_no_valid ov=%b y=%b exp 0/0000", a_ov, a_y); end
        a_sv = 1;
        tick();
        checks++; if (a_y !== 4'b0100 || a_idx !== 2'd2 || a_ov !== 1'b1) begin failures++; $display("FAIL direct_sel2 y=%b idx=%0d ov=%b exp 0100/2/1", a_y, a_idx, a_ov); end
        a_sv = 0; a_sel = 3;
        tick();
        checks++; if (a_y !== 4'b0100 || a_idx !== 2'd2 || a_ov !== 1'b1) begin failures++; $display("FAIL direct_hold y=%b idx=%0d ov=%b exp 0100/2/1", a_y, a_idx, a_ov); end
        a_sel = 0; a_sv = 1;
        tick();
        checks++; if (a_y !== 4'b0001 || a_idx !== 2'd0 || a_wrap !== 1'b0) begin failures++; $display("FAIL direct_sel0 y=%b idx=%0d wrap=%b exp 0001/0/0", a_y, a_idx, a_wrap); end
    endtask

    task automatic test_scan();
        logic [1:0] ei;
        logic [3:0] ey;
        a_sv = 0; a_mode = 1;
        for (int k = 0; k < 14; k++) begin
            tick();
            ei = 2'((k / 3) % 4);
            ey = 4'b0001 << ei;
            checks++;
            if (a_y !== ey || a_idx !== ei || a_wrap !== (k == 12) || a_ov !== 1'b1) begin
                failures++;
                $display("FAIL scan_k%0d y=%b idx=%0d wrap=%b ov=%b exp %b/%0d/%b/1", k, a_y, a_idx, a_wrap, a_ov, ey, ei, (k == 12));
            end
        end
    endtask

    task automatic test_mode_switch();
        a_mode = 0; a_sel = 0; a_sv = 1;
        tick();
        a_sv = 0; a_mode = 1;
        repeat (7) tick();
        checks++; if (a_idx !== 2'd2 || a_y !== 4'b0100) begin failures++; $display("FAIL scan_to_2 idx=%0d y=%b exp 2/0100", a_idx, a_y); end
        a_mode = 0;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++; if (a_y !== 4'b0100 || a_ov !== 1'b1 || a_idx !== 2'd2 || a_wrap !== 1'b0) begin failures++; $display("FAIL direct_from_scan_%0d y=%b ov=%b idx=%0d exp 0100/1/2", k, a_y, a_ov, a_idx); end
        end
        a_mode = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (a_idx !== 2'd2 || a_y !== 4'b0100) begin failures++; $display("FAIL resume_dwell_%0d idx=%0d y=%b exp 2/0100", k, a_idx, a_y); end
        end
        tick();
        checks++; if (a_idx !== 2'd3 || a_y !== 4'b1000 || a_wrap !== 1'b0) begin failures++; $display("FAIL resume_advance idx=%0d y=%b wrap=%b exp 3/1000/0", a_idx, a_y, a_wrap); end
        a_en = 0;
        tick();
        checks++; if (a_y !== 4'b0000 || a_ov !== 1'b0 || a_idx !== 2'd3) begin failures++; $display("FAIL scan_en_low y=%b ov=%b idx=%0d exp 0000/0/3", a_y, a_ov, a_idx); end
    endtask

    task automatic test_active_low();
        b_en = 1; b_mode = 0; b_sel = 1; b_sv = 0;
        tick();
        checks++; if (b_y !== 4'b1111 || b_ov !== 1'b0) begin failures++; $display("FAIL al_entry y=%b ov=%b exp 1111/0", b_y, b_ov); end
        b_sv = 1;
        tick();
        checks++; if (b_y !== 4'b1101 || b_idx !== 2'd1 || b_ov !== 1'b1) begin failures++; $display("FAIL al_sel1 y=%b idx=%0d ov=%b exp 1101/1/1", b_y, b_idx, b_ov); end
        b_en = 0; b_sv = 0;
        tick();
        checks++; if (b_y !== 4'b1111 || b_ov !== 1'b0) begin failures++; $display("FAIL al_disable y=%b ov=%b exp 1111/0", b_y, b_ov); end
    endtask

    task automatic test_scan_n3();
        logic [2:0] ei;
        logic [7:0] ey;
        c_en = 1; c_mode = 0; c_sel = 0; c_sv = 1;
        tick();
        c_sv = 0; c_mode = 1;
        for (int k = 0; k < 17; k++) begin
            tick();
            ei = 3'(k % 8);
            ey = 8'b0000_0001 << ei;
            checks++;
            if (c_y !== ey || c_idx !== ei || c_wrap !== (k == 8 || k == 16)) begin
                failures++;
                $display("FAIL n3_scan_k%0d y=%b idx=%0d wrap=%b exp %b/%0d/%b", k, c_y, c_idx, c_wrap, ey, ei, (k == 8 || k == 16));
            end
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_scan();
        test_mode_switch();
        test_active_low();
        test_scan_n3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
